// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
//   Handshake and payload bundle for one inter-stage pipeline register.
//   The upstream/downstream environment uses the master modport. The
//   pipeline stage itself uses the slave modport.
//
//   Upstream side  : in_valid_i, in_ready_o, in_data_i, in_ctrl_i, in_rd_i
//   Downstream side: out_valid_o, out_ready_i, out_data_o, out_ctrl_o,
//                    out_rd_o
//   Signal suffixes are named from the stage's point of view.
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned ADDR_W = 5
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic [CTRL_W-1:0] in_ctrl_i;
  logic [ADDR_W-1:0] in_rd_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic [CTRL_W-1:0] out_ctrl_o;
  logic [ADDR_W-1:0] out_rd_o;

  // Environment view: drives the upstream entry and the downstream ready.
  modport master (
    output in_valid_i, in_data_i, in_ctrl_i, in_rd_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_data_o, out_ctrl_o, out_rd_o
  );

  // Stage view: consumes the upstream entry, presents the held entry.
  modport slave (
    input  in_valid_i, in_data_i, in_ctrl_i, in_rd_i, out_ready_i,
    output in_ready_o, out_valid_o, out_data_o, out_ctrl_o, out_rd_o
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//   Generic inter-stage pipeline register (EX/MEM, MEM/WB, ...) carrying a
//   data payload, control bits and a destination register address, with
//   valid/ready flow control through a two-entry buffer (main + skid).
//
//   Ports:
//     clk_i        clock, rising edge
//     rst_i        synchronous active-low reset
//     flush_i      synchronous flush: kills held and incoming entries
//     bus          pipe_stage_skid_if.slave handshake/payload bundle
//     stall_cnt_o  16-bit saturating stall counter (PIPE_STALL_CNT_EN only)
//
//   Optional feature macro: PIPE_STALL_CNT_EN
//     When defined, stall_cnt_o counts cycles with out_valid_o=1 and
//     out_ready_i=0, saturating at 16'hFFFF, cleared only by reset.
//
//   All outputs come straight from flops. The main register drives the
//   outputs; the skid register absorbs the one entry that can arrive while
//   main is stalled, which is what lets in_ready_o be a registered signal.
//   Control bits are zeroed whenever main holds a bubble so that downstream
//   never sees a spurious write enable.
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 2,
  parameter int unsigned ADDR_W = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  pipe_stage_skid_if.slave      bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  // Registered state
  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic [ADDR_W-1:0] main_rd_r;

  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic [ADDR_W-1:0] skid_rd_r;

  logic              in_ready_r;

  // Next-state values
  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic [ADDR_W-1:0] main_rd_s;

  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [ADDR_W-1:0] skid_rd_s;

  logic              in_ready_s;

  // Handshake events for this cycle
  logic              accept_s;
  logic              drain_s;
  logic              main_load_s;

  // Handshake qualification; in_ready_r is a flop, so no ready path exists
  // from out_ready_i to in_ready_o.
  always_comb begin
    accept_s    = bus.in_valid_i & in_ready_r;
    drain_s     = main_valid_r & bus.out_ready_i;
    main_load_s = (~main_valid_r) | drain_s;
  end

  // Next-state selection for main and skid registers.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_ctrl_s  = main_ctrl_r;
    main_rd_s    = main_rd_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_rd_s    = skid_rd_r;

    if (flush_i) begin
      // Bubble insert: valids and control cleared, payload left in place.
      // An input offered this cycle is dropped even if in_ready_o is 1.
      main_valid_s = 1'b0;
      main_ctrl_s  = {CTRL_W{1'b0}};
      skid_valid_s = 1'b0;
    end else if (main_load_s) begin
      if (skid_valid_r) begin
        // Older entry waiting in skid goes first to keep FIFO order.
        // in_ready_r is 0 here, so no input can be accepted alongside.
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        main_ctrl_s  = skid_ctrl_r;
        main_rd_s    = skid_rd_r;
        skid_valid_s = 1'b0;
      end else if (accept_s) begin
        main_valid_s = 1'b1;
        main_data_s  = bus.in_data_i;
        main_ctrl_s  = bus.in_ctrl_i;
        main_rd_s    = bus.in_rd_i;
      end else begin
        // Nothing to load: main becomes a bubble, payload holds.
        main_valid_s = 1'b0;
        main_ctrl_s  = {CTRL_W{1'b0}};
      end
    end else if (accept_s) begin
      // Main is stalled with a valid entry: park the new one in skid.
      skid_valid_s = 1'b1;
      skid_data_s  = bus.in_data_i;
      skid_ctrl_s  = bus.in_ctrl_i;
      skid_rd_s    = bus.in_rd_i;
    end else begin
      skid_valid_s = skid_valid_r;
    end

    in_ready_s = ~skid_valid_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_W{1'b0}};
      main_ctrl_r  <= {CTRL_W{1'b0}};
      main_rd_r    <= {ADDR_W{1'b0}};
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_ctrl_r  <= {CTRL_W{1'b0}};
      skid_rd_r    <= {ADDR_W{1'b0}};
      in_ready_r   <= 1'b1;
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_ctrl_r  <= main_ctrl_s;
      main_rd_r    <= main_rd_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_rd_r    <= skid_rd_s;
      in_ready_r   <= in_ready_s;
    end
  end

  assign bus.in_ready_o  = in_ready_r;
  assign bus.out_valid_o = main_valid_r;
  assign bus.out_data_o  = main_data_r;
  assign bus.out_ctrl_o  = main_ctrl_r;
  assign bus.out_rd_o    = main_rd_r;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_r;
  logic [15:0] stall_cnt_s;

  // Saturating stall count; flush leaves it untouched.
  always_comb begin
    if (main_valid_r && !bus.out_ready_i && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_s = stall_cnt_r + 16'd1;
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // Stall counter register, cleared only by reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_r <= 16'd0;
    end else begin
      stall_cnt_r <= stall_cnt_s;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_skid
//   Self-checking bench for pipe_stage_skid: a directed vector table, a few
//   hand-written multi-cycle sequences, and randomized traffic compared
//   against a queue-based reference model (at most two entries in flight).
// ---------------------------------------------------------------------------
module tb_pipe_stage_skid;

  logic clk;
  logic rst;
  logic flush;

  pipe_stage_skid_if #(.DATA_W(64), .CTRL_W(2), .ADDR_W(5)) bus ();

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] m_stall;
`endif

  pipe_stage_skid #(.DATA_W(64), .CTRL_W(2), .ADDR_W(5)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .flush_i (flush),
    .bus     (bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: ordered list of in-flight entries plus the payload
  // last presented at the output (payload holds across bubbles).
  typedef struct packed {
    logic [63:0] d;
    logic [1:0]  c;
    logic [4:0]  rd;
  } ent_t;

  ent_t        q[$];
  logic [63:0] disp_d;
  logic [4:0]  disp_rd;

  typedef struct packed {
    logic        rst;
    logic        fl;
    logic        iv;
    logic [63:0] d;
    logic [1:0]  c;
    logic [4:0]  rd;
    logic        ordy;
    logic        ev;
    logic        er;
    logic [63:0] ed;
    logic [1:0]  ec;
    logic [4:0]  erd;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, settle past edge.
  task automatic apply(input logic r, input logic fl, input logic iv,
                       input logic [63:0] d, input logic [1:0] c,
                       input logic [4:0] rd, input logic ordy);
    bit push;
    rst   = r;
    flush = fl;
    bus.in_valid_i  = iv;
    bus.in_data_i   = d;
    bus.in_ctrl_i   = c;
    bus.in_rd_i     = rd;
    bus.out_ready_i = ordy;

    if (!r) begin
      q.delete();
      disp_d  = 64'd0;
      disp_rd = 5'd0;
`ifdef PIPE_STALL_CNT_EN
      m_stall = 16'd0;
`endif
    end else begin
`ifdef PIPE_STALL_CNT_EN
      if (q.size() > 0 && !ordy && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
      if (fl) begin
        q.delete();
      end else begin
        push = iv && (q.size() < 2);
        if (q.size() > 0 && ordy) void'(q.pop_front());
        if (push) q.push_back('{d: d, c: c, rd: rd});
      end
      if (q.size() > 0) begin
        disp_d  = q[0].d;
        disp_rd = q[0].rd;
      end
    end

    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".valid"}, 64'(bus.out_valid_o), 64'(q.size() > 0));
    check({tag, ".ready"}, 64'(bus.in_ready_o),  64'(q.size() < 2));
    check({tag, ".data"},  bus.out_data_o,       disp_d);
    check({tag, ".ctrl"},  64'(bus.out_ctrl_o),  64'((q.size() > 0) ? q[0].c : 2'b00));
    check({tag, ".rd"},    64'(bus.out_rd_o),    64'(disp_rd));
`ifdef PIPE_STALL_CNT_EN
    check({tag, ".stall"}, 64'(stall_cnt),       64'(m_stall));
`endif
  endtask

  function automatic vec_t mk(input logic r, input logic fl, input logic iv,
                              input logic [63:0] d, input logic [1:0] c,
                              input logic [4:0] rd, input logic ordy,
                              input logic ev, input logic er,
                              input logic [63:0] ed, input logic [1:0] ec,
                              input logic [4:0] erd);
    vec_t v;
    v = '{rst: r, fl: fl, iv: iv, d: d, c: c, rd: rd, ordy: ordy,
          ev: ev, er: er, ed: ed, ec: ec, erd: erd};
    return v;
  endfunction

  initial begin
    rst   = 1'b0;
    flush = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_data_i   = 64'd0;
    bus.in_ctrl_i   = 2'b00;
    bus.in_rd_i     = 5'd0;
    bus.out_ready_i = 1'b0;
    disp_d  = 64'd0;
    disp_rd = 5'd0;
`ifdef PIPE_STALL_CNT_EN
    m_stall = 16'd0;
`endif

    // ---- Directed table: reset, streaming, backpressure ----
    //             rst  fl   iv   data          ctrl   rd    ordy  ev   er   exp_data      ectrl  erd
    vecs[0]  = mk(1'b0,1'b0,1'b1,64'hDEAD,     2'b11,5'd1, 1'b0, 1'b0,1'b1,64'h0,        2'b00, 5'd0);
    vecs[1]  = mk(1'b0,1'b0,1'b1,64'hDEAD,     2'b11,5'd1, 1'b0, 1'b0,1'b1,64'h0,        2'b00, 5'd0);
    vecs[2]  = mk(1'b1,1'b0,1'b1,64'hDEAD,     2'b11,5'd1, 1'b1, 1'b1,1'b1,64'hDEAD,     2'b11, 5'd1);
    for (int k = 1; k <= 8; k++) begin
      vecs[2+k] = mk(1'b1,1'b0,1'b1,64'(k),    2'b11,5'd7, 1'b1, 1'b1,1'b1,64'(k),       2'b11, 5'd7);
    end
    vecs[11] = mk(1'b1,1'b0,1'b0,64'h0,        2'b00,5'd0, 1'b1, 1'b0,1'b1,64'd8,        2'b00, 5'd7);
    vecs[12] = mk(1'b1,1'b0,1'b1,64'hA,        2'b01,5'd2, 1'b0, 1'b1,1'b1,64'hA,        2'b01, 5'd2);
    vecs[13] = mk(1'b1,1'b0,1'b1,64'hB,        2'b10,5'd3, 1'b0, 1'b1,1'b0,64'hA,        2'b01, 5'd2);
    vecs[14] = mk(1'b1,1'b0,1'b1,64'hC,        2'b11,5'd4, 1'b0, 1'b1,1'b0,64'hA,        2'b01, 5'd2);
    vecs[15] = mk(1'b1,1'b0,1'b1,64'hC,        2'b11,5'd4, 1'b1, 1'b1,1'b1,64'hB,        2'b10, 5'd3);
    vecs[16] = mk(1'b1,1'b0,1'b1,64'hC,        2'b11,5'd4, 1'b1, 1'b1,1'b1,64'hC,        2'b11, 5'd4);
    vecs[17] = mk(1'b1,1'b0,1'b0,64'h0,        2'b00,5'd0, 1'b1, 1'b0,1'b1,64'hC,        2'b00, 5'd4);

    for (int i = 0; i < 18; i++) begin
      apply(vecs[i].rst, vecs[i].fl, vecs[i].iv, vecs[i].d, vecs[i].c, vecs[i].rd, vecs[i].ordy);
      check($sformatf("tbl%0d.valid", i), 64'(bus.out_valid_o), 64'(vecs[i].ev));
      check($sformatf("tbl%0d.ready", i), 64'(bus.in_ready_o),  64'(vecs[i].er));
      check($sformatf("tbl%0d.data", i),  bus.out_data_o,       vecs[i].ed);
      check($sformatf("tbl%0d.ctrl", i),  64'(bus.out_ctrl_o),  64'(vecs[i].ec));
      check($sformatf("tbl%0d.rd", i),    64'(bus.out_rd_o),    64'(vecs[i].erd));
    end

    // ---- Flush with main=A, skid=B and C offered ----
    apply(1'b1, 1'b0, 1'b1, 64'h1A, 2'b11, 5'd10, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 64'h1B, 2'b11, 5'd11, 1'b0);
    check("flush.pre_full", 64'(bus.in_ready_o), 64'd0);
    apply(1'b1, 1'b1, 1'b1, 64'h1C, 2'b11, 5'd12, 1'b0);
    check("flush.valid", 64'(bus.out_valid_o), 64'd0);
    check("flush.ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("flush.ready", 64'(bus.in_ready_o),  64'd1);
    check("flush.hold",  bus.out_data_o,       64'h1A);
    apply(1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 5'd0, 1'b1);
    check("flush.no_c",  64'(bus.out_valid_o), 64'd0);
    check_model("flush.model");

    // ---- Reset while main and skid are both full and stalled ----
    apply(1'b1, 1'b0, 1'b1, 64'h2A, 2'b01, 5'd20, 1'b0);
    apply(1'b1, 1'b0, 1'b1, 64'h2B, 2'b10, 5'd21, 1'b0);
    apply(1'b0, 1'b0, 1'b1, 64'h2C, 2'b11, 5'd22, 1'b0);
    check("rst_mid.valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_mid.ready", 64'(bus.in_ready_o),  64'd1);
    check("rst_mid.data",  bus.out_data_o,       64'd0);
    check("rst_mid.ctrl",  64'(bus.out_ctrl_o),  64'd0);
    check("rst_mid.rd",    64'(bus.out_rd_o),    64'd0);
    apply(1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 5'd0, 1'b1);
    check("rst_mid.empty", 64'(bus.out_valid_o), 64'd0);

`ifdef PIPE_STALL_CNT_EN
    // ---- Stall counter: 10 stalled cycles, then saturation ----
    apply(1'b1, 1'b0, 1'b1, 64'h3A, 2'b11, 5'd1, 1'b0);
    for (int i = 0; i < 10; i++) apply(1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    check("stall.ten", 64'(stall_cnt), 64'd10);
    force dut.stall_cnt_r = 16'hFFFE;
    #1;
    release dut.stall_cnt_r;
    m_stall = 16'hFFFE;
    for (int i = 0; i < 3; i++) apply(1'b1, 1'b0, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    check("stall.sat", 64'(stall_cnt), 64'hFFFF);
    apply(1'b1, 1'b1, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    check("stall.flush_keeps", 64'(stall_cnt), 64'hFFFF);
    apply(1'b0, 1'b0, 1'b0, 64'h0, 2'b00, 5'd0, 1'b0);
    check("stall.rst", 64'(stall_cnt), 64'd0);
`endif

    // ---- Randomized traffic against the reference model ----
    for (int i = 0; i < 600; i++) begin
      logic r, fl, iv, ordy;
      r    = ($urandom_range(0, 59) != 0);
      fl   = ($urandom_range(0, 19) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      apply(r, fl, iv, {$urandom, $urandom}, 2'($urandom), 5'($urandom), ordy);
      check_model($sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
